// File: rtl/mem_mon_pkg.sv
// Shared types for the memory bus monitor: run-state and fail-cause encodings
// plus the packed trace entry stored by the ring buffer.
package mem_mon_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_PASS = 2'd2,
    ST_FAIL = 2'd3
  } mon_state_t;

  typedef enum logic [1:0] {
    CAUSE_NONE    = 2'd0,
    CAUSE_TRAP    = 2'd1,
    CAUSE_STALL   = 2'd2,
    CAUSE_TIMEOUT = 2'd3
  } fail_cause_t;

  // Trace entry field widths; the monitor's ADDR_W/DATA_W may not exceed these.
  localparam int unsigned MON_ADDR_W = 32;
  localparam int unsigned MON_DATA_W = 32;

  typedef struct packed {
    logic                  wr;
    logic [MON_ADDR_W-1:0] addr;
    logic [MON_DATA_W-1:0] data;
  } trace_entry_t;

endpackage

// File: rtl/mem_bus_monitor_if.sv
// CPU native memory bus plus the core trap line.
// Handshake: a transfer completes on every clock edge where mem_valid && mem_ready;
// the master holds mem_addr/mem_wdata/mem_wstrb stable while mem_valid is high and
// not yet accepted; mem_wstrb == 0 marks a read whose data is mem_rdata.
interface mem_bus_monitor_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              mem_valid;
  logic              mem_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W/8-1:0] mem_wstrb;
  logic [DATA_W-1:0] mem_rdata;
  logic              trap;

  modport master (
    output mem_valid, mem_addr, mem_wdata, mem_wstrb, trap,
    input  mem_ready, mem_rdata
  );

  modport slave (
    input  mem_valid, mem_addr, mem_wdata, mem_wstrb,
    output mem_ready, mem_rdata
  );

  modport monitor (
    input mem_valid, mem_ready, mem_addr, mem_wdata, mem_wstrb, mem_rdata, trap
  );
endinterface

// File: rtl/mem_mon_trace_buf.sv
// Ring buffer of the most recent bus transfers with a registered,
// newest-relative indexed read port.
module mem_mon_trace_buf
  import mem_mon_pkg::*;
#(
  parameter  int DEPTH = 8,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  trace_entry_t     wentry,
  input  logic [IDX_W-1:0] rd_idx,
  output logic             rd_valid,
  output trace_entry_t     rd_entry
);

  localparam int CNT_BITS = IDX_W + 1;
  localparam logic [CNT_BITS-1:0] FULL = CNT_BITS'(DEPTH);

  trace_entry_t          ring [DEPTH];
  logic [IDX_W-1:0]      wptr;
  logic [CNT_BITS-1:0]   count;
  logic [IDX_W-1:0]      rd_phys;

  // DEPTH is a power of two, so pointer arithmetic wraps for free.
  assign rd_phys = wptr - IDX_W'(1) - rd_idx;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) ring[i] <= '0;
      wptr     <= '0;
      count    <= '0;
      rd_valid <= 1'b0;
      rd_entry <= '0;
    end else begin
      if (we) begin
        ring[wptr] <= wentry;
        wptr       <= wptr + IDX_W'(1);
        if (count != FULL) count <= count + CNT_BITS'(1);
      end
      // Non-blocking read sees pre-write contents on a same-entry collision.
      rd_valid <= ({1'b0, rd_idx} < count);
      rd_entry <= ring[rd_phys];
    end
  end

endmodule

// File: rtl/mem_bus_monitor.sv
// Bus monitor: IDLE/RUN/PASS/FAIL run tracker with saturating counters,
// prioritised exit detection and a trace of recent transfers.
module mem_bus_monitor
  import mem_mon_pkg::*;
#(
  parameter  int              ADDR_W      = 32,
  parameter  int              DATA_W      = 32,
  parameter  logic [ADDR_W-1:0] DONE_ADDR = 32'h0000_0010,
  parameter  int              TIMEOUT_CYC = 1_000_000,
  parameter  int              STALL_MAX   = 1024,
  parameter  int              CNT_W       = 32,
  parameter  int              TRACE_DEPTH = 8,
  localparam int              IDX_W       = $clog2(TRACE_DEPTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               mon_en,
  mem_bus_monitor_if.monitor bus,
  output logic [1:0]         state,
  output logic [1:0]         fail_cause,
  output logic [DATA_W-1:0]  result,
  output logic [CNT_W-1:0]   cycle_cnt,
  output logic [CNT_W-1:0]   rd_cnt,
  output logic [CNT_W-1:0]   wr_cnt,
  output logic [CNT_W-1:0]   stall_cnt,
  input  logic [IDX_W-1:0]   trace_idx,
  output logic               trace_valid,
  output logic               trace_wr,
  output logic [ADDR_W-1:0]  trace_addr,
  output logic [DATA_W-1:0]  trace_data
);

  mon_state_t   st;
  fail_cause_t  cause;
  logic [CNT_W-1:0] stall_run;

  logic xfer, is_wr, stall, in_run;
  logic stall_hit, done_hit, timeout_hit;
  trace_entry_t wentry, rd_entry;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

  assign in_run = (st == ST_RUN);
  assign xfer   = bus.mem_valid && bus.mem_ready;
  assign is_wr  = |bus.mem_wstrb;
  assign stall  = bus.mem_valid && !bus.mem_ready;

  // stall_run counts prior stall cycles, so this fires on the STALL_MAX-th stall.
  assign stall_hit   = stall && (stall_run == CNT_W'(STALL_MAX - 1));
  assign done_hit    = xfer && is_wr && (bus.mem_addr == DONE_ADDR);
  assign timeout_hit = (cycle_cnt == CNT_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      st        <= ST_IDLE;
      cause     <= CAUSE_NONE;
      result    <= '0;
      cycle_cnt <= '0;
      rd_cnt    <= '0;
      wr_cnt    <= '0;
      stall_cnt <= '0;
      stall_run <= '0;
    end else begin
      case (st)
        ST_IDLE: begin
          if (mon_en) begin
            st        <= ST_RUN;
            cycle_cnt <= '0;
            rd_cnt    <= '0;
            wr_cnt    <= '0;
            stall_cnt <= '0;
            stall_run <= '0;
          end
        end
        ST_RUN: begin
          cycle_cnt <= sat_inc(cycle_cnt);
          if (xfer && is_wr)  wr_cnt <= sat_inc(wr_cnt);
          if (xfer && !is_wr) rd_cnt <= sat_inc(rd_cnt);
          if (stall) begin
            stall_cnt <= sat_inc(stall_cnt);
            stall_run <= sat_inc(stall_run);
          end else begin
            stall_run <= '0;
          end
          if (bus.trap) begin
            st    <= ST_FAIL;
            cause <= CAUSE_TRAP;
          end else if (stall_hit) begin
            st    <= ST_FAIL;
            cause <= CAUSE_STALL;
          end else if (done_hit) begin
            st     <= ST_PASS;
            result <= bus.mem_wdata;
          end else if (timeout_hit) begin
            st    <= ST_FAIL;
            cause <= CAUSE_TIMEOUT;
          end
        end
        default: ; // PASS and FAIL are terminal until reset
      endcase
    end
  end

  assign state      = st;
  assign fail_cause = cause;

  assign wentry = '{wr:   is_wr,
                    addr: MON_ADDR_W'(bus.mem_addr),
                    data: is_wr ? MON_DATA_W'(bus.mem_wdata) : MON_DATA_W'(bus.mem_rdata)};

  mem_mon_trace_buf #(.DEPTH(TRACE_DEPTH)) u_trace (
    .clk      (clk),
    .rst      (rst),
    .we       (in_run && xfer),
    .wentry   (wentry),
    .rd_idx   (trace_idx),
    .rd_valid (trace_valid),
    .rd_entry (rd_entry)
  );

  assign trace_wr   = rd_entry.wr;
  assign trace_addr = ADDR_W'(rd_entry.addr);
  assign trace_data = DATA_W'(rd_entry.data);

endmodule

// File: tb/tb_mem_bus_monitor.sv
// Directed and randomized bench for mem_bus_monitor against a cycle-level
// behavioural model of the run rules and a newest-first trace queue.
module tb_mem_bus_monitor;
  import mem_mon_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int TO = 50;
  localparam int SM = 4;
  localparam int TD = 4;
  localparam int IW = 2;
  localparam int TW = 1 + AW + DW;
  localparam logic [AW-1:0] DONE = 32'h10;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          mon_en = 1'b0;
  logic [IW-1:0] trace_idx = '0;
  logic [1:0]    state, fail_cause;
  logic [DW-1:0] result, trace_data;
  logic [31:0]   cycle_cnt, rd_cnt, wr_cnt, stall_cnt;
  logic          trace_valid, trace_wr;
  logic [AW-1:0] trace_addr;

  mem_bus_monitor_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  mem_bus_monitor #(
    .ADDR_W(AW), .DATA_W(DW), .DONE_ADDR(DONE), .TIMEOUT_CYC(TO),
    .STALL_MAX(SM), .CNT_W(32), .TRACE_DEPTH(TD)
  ) dut (
    .clk(clk), .rst(rst), .mon_en(mon_en), .bus(bus),
    .state(state), .fail_cause(fail_cause), .result(result),
    .cycle_cnt(cycle_cnt), .rd_cnt(rd_cnt), .wr_cnt(wr_cnt), .stall_cnt(stall_cnt),
    .trace_idx(trace_idx), .trace_valid(trace_valid), .trace_wr(trace_wr),
    .trace_addr(trace_addr), .trace_data(trace_data)
  );

  // scoreboard / reference model
  int checks = 0;
  int errors = 0;
  logic [TW-1:0] exp_q[$];   // newest transfer at the front
  int m_state, m_cause, m_cyc, m_rd, m_wr, m_stall, m_run;
  logic [DW-1:0] m_result;
  logic          e_tv;
  logic [TW-1:0] e_ent;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".state"},  32'(state),      32'(m_state));
    chk({tag, ".cause"},  32'(fail_cause), 32'(m_cause));
    chk({tag, ".result"}, result,          m_result);
    chk({tag, ".cycles"}, cycle_cnt,       32'(m_cyc));
    chk({tag, ".rd_cnt"}, rd_cnt,          32'(m_rd));
    chk({tag, ".wr_cnt"}, wr_cnt,          32'(m_wr));
    chk({tag, ".stalls"}, stall_cnt,       32'(m_stall));
    chk({tag, ".tvalid"}, 32'(trace_valid), 32'(e_tv));
    if (e_tv) begin
      chk({tag, ".twr"},   32'(trace_wr), 32'(e_ent[TW-1]));
      chk({tag, ".taddr"}, trace_addr,    e_ent[AW+DW-1:DW]);
      chk({tag, ".tdata"}, trace_data,    e_ent[DW-1:0]);
    end
  endtask

  task automatic model_clear();
    m_state = 0; m_cause = 0; m_cyc = 0; m_rd = 0; m_wr = 0; m_stall = 0; m_run = 0;
    m_result = '0;
    exp_q.delete();
    e_tv = 1'b0;
    e_ent = '0;
  endtask

  // One clock of the run rules, written from the behavioural description.
  task automatic model_cycle(input logic en, v, r, input logic [AW-1:0] a,
                             input logic [DW-1:0] wd, input logic [SW-1:0] ws,
                             input logic [DW-1:0] rd, input logic tp);
    bit done, is_wr, stl;
    done  = v && r;
    is_wr = (ws != 0);
    stl   = v && !r;
    // trace read returns what the buffer held before this edge
    if (int'(trace_idx) < exp_q.size()) begin
      e_tv = 1'b1; e_ent = exp_q[trace_idx];
    end else begin
      e_tv = 1'b0; e_ent = '0;
    end
    if (m_state == 0) begin
      if (en) m_state = 1;
    end else if (m_state == 1) begin
      m_cyc++;
      if (done) begin
        if (is_wr) m_wr++; else m_rd++;
        exp_q.push_front({is_wr, a, is_wr ? wd : rd});
        if (exp_q.size() > TD) void'(exp_q.pop_back());
      end
      if (stl) begin m_stall++; m_run++; end else m_run = 0;
      if (tp) begin m_state = 3; m_cause = 1; end
      else if (stl && m_run == SM) begin m_state = 3; m_cause = 2; end
      else if (done && is_wr && a == DONE) begin m_state = 2; m_result = wd; end
      else if (m_cyc == TO) begin m_state = 3; m_cause = 3; end
    end
  endtask

  // driver tasks
  task automatic step(input logic en, v, r, input logic [AW-1:0] a,
                      input logic [DW-1:0] wd, input logic [SW-1:0] ws,
                      input logic [DW-1:0] rd, input logic tp);
    mon_en = en; bus.mem_valid = v; bus.mem_ready = r; bus.mem_addr = a;
    bus.mem_wdata = wd; bus.mem_wstrb = ws; bus.mem_rdata = rd; bus.trap = tp;
    model_cycle(en, v, r, a, wd, ws, rd, tp);
    @(posedge clk); #1;
    check_all("step");
  endtask

  task automatic do_reset();
    rst = 1'b1; mon_en = 1'b0; trace_idx = '0;
    bus.mem_valid = 0; bus.mem_ready = 0; bus.mem_addr = '0; bus.mem_wdata = '0;
    bus.mem_wstrb = '0; bus.mem_rdata = '0; bus.trap = 0;
    @(posedge clk); #1;
    model_clear();
    check_all("reset");
    rst = 1'b0;
  endtask

  task automatic start();                     step(1, 0, 0, '0, '0, '0, '0, 0); endtask
  task automatic idle(input int n);           repeat (n) step(0, 0, 0, '0, '0, '0, '0, 0); endtask
  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d); step(0, 1, 1, a, d, '1, '0, 0); endtask
  task automatic rd(input logic [AW-1:0] a, input logic [DW-1:0] d); step(0, 1, 1, a, '0, '0, d, 0); endtask
  task automatic stall_cyc();                 step(0, 1, 0, 32'h40, '0, '0, '0, 0); endtask

  initial begin
    // mailbox PASS on RUN cycle 10, then frozen
    do_reset();
    chk("rst.state", 32'(state), 32'd0);
    chk("rst.cycles", cycle_cnt, 32'd0);
    start();
    rd(32'h0, 32'h1111);
    rd(32'h4, 32'h2222);
    wr(32'h100, 32'hAA);
    idle(6);
    wr(32'h10, 32'h1234_5678);
    chk("pass.state", 32'(state), 32'd2);
    chk("pass.result", result, 32'h1234_5678);
    chk("pass.rd", rd_cnt, 32'd2);
    chk("pass.wr", wr_cnt, 32'd2);
    chk("pass.cycles", cycle_cnt, 32'd10);
    wr(32'h200, 32'h55);
    rd(32'h8, 32'h77);
    step(1, 1, 1, 32'h10, 32'h9, '1, '0, 1);
    chk("pass.sticky", 32'(state), 32'd2);
    chk("pass.sticky_wr", wr_cnt, 32'd2);

    // trap beats a same-cycle mailbox write
    do_reset();
    start();
    step(0, 1, 1, DONE, 32'hDEAD, '1, '0, 1);
    chk("trap.state", 32'(state), 32'd3);
    chk("trap.cause", 32'(fail_cause), 32'd1);
    chk("trap.result", result, 32'd0);

    // stall limit
    do_reset();
    start();
    repeat (3) stall_cyc();
    chk("stall.run3", 32'(state), 32'd1);
    stall_cyc();
    chk("stall.state", 32'(state), 32'd3);
    chk("stall.cause", 32'(fail_cause), 32'd2);
    chk("stall.cnt", stall_cnt, 32'd4);
    do_reset();
    start();
    repeat (3) stall_cyc();
    rd(32'h40, 32'h5);
    repeat (3) stall_cyc();
    chk("stall.ready_saves", 32'(state), 32'd1);
    chk("stall.cnt6", stall_cnt, 32'd6);

    // timeout, and mailbox on the timeout cycle
    do_reset();
    start();
    idle(TO);
    chk("tmo.state", 32'(state), 32'd3);
    chk("tmo.cause", 32'(fail_cause), 32'd3);
    chk("tmo.cycles", cycle_cnt, 32'(TO));
    do_reset();
    start();
    idle(TO - 1);
    wr(DONE, 32'hCAFE);
    chk("tmo_pass.state", 32'(state), 32'd2);
    chk("tmo_pass.cycles", cycle_cnt, 32'(TO));

    // trace wrap and indexed readout
    do_reset();
    start();
    for (int i = 0; i < 6; i++) wr(32'h20 + 32'(4 * i), 32'(i + 1));
    trace_idx = 2'd0;
    idle(1);
    chk("trace.idx0_addr", trace_addr, 32'h34);
    chk("trace.idx0_valid", 32'(trace_valid), 32'd1);
    trace_idx = 2'd3;
    idle(1);
    chk("trace.idx3_addr", trace_addr, 32'h28);
    chk("trace.idx3_valid", 32'(trace_valid), 32'd1);
    do_reset();
    start();
    wr(32'h20, 32'h1);
    rd(32'h24, 32'h2);
    trace_idx = 2'd2;
    idle(1);
    chk("trace.short_valid", 32'(trace_valid), 32'd0);
    trace_idx = 2'd1;
    idle(1);
    chk("trace.idx1_addr", trace_addr, 32'h20);

    // reset mid-run, then a fresh run
    do_reset();
    start();
    rd(32'h0, 32'h3);
    wr(32'h30, 32'h4);
    stall_cyc();
    do_reset();
    chk("midrst.state", 32'(state), 32'd0);
    chk("midrst.wr", wr_cnt, 32'd0);
    chk("midrst.tvalid", 32'(trace_valid), 32'd0);
    start();
    rd(32'h8, 32'h6);
    chk("midrst.fresh_rd", rd_cnt, 32'd1);
    chk("midrst.fresh_cyc", cycle_cnt, 32'd1);

    // randomized runs against the model
    for (int run = 0; run < 24; run++) begin
      do_reset();
      start();
      for (int c = 0; c < TO + 4; c++) begin
        logic v, r, tp;
        logic [AW-1:0] a;
        logic [SW-1:0] ws;
        v  = ($urandom_range(0, 3) != 0);
        r  = ($urandom_range(0, 2) != 0);
        tp = ($urandom_range(0, 119) == 0);
        a  = ($urandom_range(0, 24) == 0) ? DONE : 32'($urandom_range(0, 63)) << 2;
        ws = ($urandom_range(0, 1) != 0) ? SW'($urandom_range(1, 15)) : '0;
        trace_idx = IW'($urandom_range(0, TD - 1));
        step(1'($urandom_range(0, 1)), v, r, a, $urandom, ws, $urandom, tp);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
